// File: rtl/prog_loader.sv
// Program loader: streams machine-code words into instruction memory, pulses
// the processor start, then times the run until cpu_done or a cycle limit.
module prog_loader #(
  parameter int              D         = 12,
  parameter int              W         = 9,
  parameter int              START_CYC = 2,
  parameter int              CW        = 24,
  parameter logic [CW-1:0]   MAX_CYC   = {CW{1'b1}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_req,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          im_wr_en,
  output logic [D-1:0]  im_wr_addr,
  output logic [W-1:0]  im_wr_data,
  output logic          cpu_start,
  input  logic          cpu_done,
  output logic          busy,
  output logic          finished,
  output logic          timeout,
  output logic          overflow,
  output logic [D:0]    word_count,
  output logic [CW-1:0] cyc_count
);

  localparam int SW = (START_CYC > 1) ? $clog2(START_CYC) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, FIN} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] sc_q, sc_d;
  logic          wr_en_q, wr_en_d;
  logic [D-1:0]  wr_addr_q, wr_addr_d;
  logic [W-1:0]  wr_data_q, wr_data_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          fin_q, fin_d;
  logic          to_q, to_d;
  logic          ov_q, ov_d;
  logic [D:0]    wc_q, wc_d;
  logic [CW-1:0] cc_q, cc_d;

  always_comb begin
    state_d   = state_q;
    sc_d      = sc_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    to_d      = to_q;
    ov_d      = ov_q;
    wc_d      = wc_q;
    cc_d      = cc_q;
    case (state_q)
      IDLE, FIN: begin
        if (load_req) begin
          state_d = LOAD;
          wc_d    = '0;
          cc_d    = '0;
          to_d    = 1'b0;
          ov_d    = 1'b0;
        end
      end
      LOAD: begin
        if (in_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = wc_q[D-1:0];
          wr_data_d = in_data;
          wc_d      = wc_q + (D+1)'(1);
          // Last slot filled without in_last: stop before the address wraps.
          if (in_last) begin
            state_d = START;
            sc_d    = '0;
          end else if (&wc_q[D-1:0]) begin
            state_d = START;
            sc_d    = '0;
            ov_d    = 1'b1;
          end
        end
      end
      START: begin
        if (sc_q == SW'(START_CYC - 1)) begin
          state_d = RUN;
          cc_d    = '0;
        end else begin
          sc_d = sc_q + SW'(1);
        end
      end
      RUN: begin
        // cpu_done wins over the cycle limit when both land together.
        if (cpu_done) begin
          state_d = FIN;
        end else if (cc_q == MAX_CYC) begin
          state_d = FIN;
          to_d    = 1'b1;
        end else begin
          cc_d = cc_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    start_d = (state_d == START);
    busy_d  = (state_d == LOAD) || (state_d == START) || (state_d == RUN);
    fin_d   = (state_d == FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sc_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      fin_q     <= 1'b0;
      to_q      <= 1'b0;
      ov_q      <= 1'b0;
      wc_q      <= '0;
      cc_q      <= '0;
    end else begin
      state_q   <= state_d;
      sc_q      <= sc_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      fin_q     <= fin_d;
      to_q      <= to_d;
      ov_q      <= ov_d;
      wc_q      <= wc_d;
      cc_q      <= cc_d;
    end
  end

  assign in_ready   = (state_q == LOAD);
  assign im_wr_en   = wr_en_q;
  assign im_wr_addr = wr_addr_q;
  assign im_wr_data = wr_data_q;
  assign cpu_start  = start_q;
  assign busy       = busy_q;
  assign finished   = fin_q;
  assign timeout    = to_q;
  assign overflow   = ov_q;
  assign word_count = wc_q;
  assign cyc_count  = cc_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a default-sized instance and a small one (D=3,
// MAX_CYC=5) share stimulus; each scenario checks the instance it targets.
module tb_prog_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, load_req = 1'b0, in_valid = 1'b0, in_last = 1'b0, cpu_done = 1'b0;
  logic [8:0] in_data = '0;

  logic a_in_ready, a_wr_en, a_start, a_busy, a_fin, a_to, a_ov;
  logic [11:0] a_wr_addr;
  logic [8:0]  a_wr_data;
  logic [12:0] a_wc;
  logic [23:0] a_cc;
  logic b_in_ready, b_wr_en, b_start, b_busy, b_fin, b_to, b_ov;
  logic [2:0]  b_wr_addr;
  logic [8:0]  b_wr_data;
  logic [3:0]  b_wc;
  logic [23:0] b_cc;

  prog_loader #(.D(12), .W(9), .START_CYC(2), .CW(24)) dut_a (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(a_in_ready),
    .im_wr_en(a_wr_en), .im_wr_addr(a_wr_addr), .im_wr_data(a_wr_data),
    .cpu_start(a_start), .cpu_done(cpu_done), .busy(a_busy), .finished(a_fin),
    .timeout(a_to), .overflow(a_ov), .word_count(a_wc), .cyc_count(a_cc));

  prog_loader #(.D(3), .W(9), .START_CYC(2), .CW(24), .MAX_CYC(24'd5)) dut_b (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(b_in_ready),
    .im_wr_en(b_wr_en), .im_wr_addr(b_wr_addr), .im_wr_data(b_wr_data),
    .cpu_start(b_start), .cpu_done(cpu_done), .busy(b_busy), .finished(b_fin),
    .timeout(b_to), .overflow(b_ov), .word_count(b_wc), .cyc_count(b_cc));

  int errs = 0, checks = 0;
  int a_wa[$], a_wd[$], b_wa[$], b_wd[$];
  int a_starts = 0, b_starts = 0;

  // Observed write and start-pulse history, sampled mid-cycle.
  always @(negedge clk) begin
    if (a_wr_en) begin a_wa.push_back(int'(a_wr_addr)); a_wd.push_back(int'(a_wr_data)); end
    if (b_wr_en) begin b_wa.push_back(int'(b_wr_addr)); b_wd.push_back(int'(b_wr_data)); end
    if (a_start) a_starts++;
    if (b_start) b_starts++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; load_req = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_data = '0; cpu_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic start_load();
    load_req = 1'b1;
    step();
    load_req = 1'b0;
  endtask

  task automatic send_word(input int sel, input logic [8:0] d, input bit last, input int gap);
    int k;
    in_valid = 1'b0;
    repeat (gap) step();
    in_valid = 1'b1; in_data = d; in_last = last;
    k = 0;
    while (!(sel ? b_in_ready : a_in_ready) && k < 20) begin step(); k++; end
    if (k >= 20) begin
      checks++; errs++;
      $display("FAIL send_word: in_ready never 1 (sel=%0d)", sel);
    end
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Returns in the first RUN cycle (cpu_start has just dropped).
  task automatic wait_run(input int sel);
    int k;
    k = 0;
    while (!(sel ? b_start : a_start) && k < 50) begin step(); k++; end
    while ((sel ? b_start : a_start) && k < 50) begin step(); k++; end
    if (k >= 50) begin
      checks++; errs++;
      $display("FAIL wait_run: no start pulse seen (sel=%0d)", sel);
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) step();
    cpu_done = 1'b1;
    step();
    cpu_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({a_in_ready, a_wr_en, a_start, a_busy, a_fin, a_to, a_ov, a_wr_addr, a_wr_data, a_wc, a_cc} !== '0) begin
      errs++; $display("FAIL reset_state: dut_a outputs not all 0");
    end
    checks++;
    if ({b_in_ready, b_wr_en, b_start, b_busy, b_fin, b_to, b_ov, b_wc, b_cc} !== '0) begin
      errs++; $display("FAIL reset_state: dut_b outputs not all 0");
    end
    do_reset();
    repeat (4) step();
    checks++;
    if (a_busy !== 1'b0 || a_in_ready !== 1'b0) begin
      errs++; $display("FAIL idle_hold: busy=%b in_ready=%b, want 0 0", a_busy, a_in_ready);
    end
  endtask

  task automatic test_basic();
    int n0, s0;
    logic [8:0] w[3] = '{9'h1A5, 9'h0C3, 9'h1FF};
    do_reset();
    n0 = a_wa.size(); s0 = a_starts;
    start_load();
    for (int i = 0; i < 3; i++) send_word(0, w[i], i == 2, 0);
    wait_run(0);
    checks++;
    if (a_starts - s0 != 2) begin errs++; $display("FAIL basic_start_len: got %0d want 2", a_starts - s0); end
    run_cycles(10);
    checks++;
    if (a_wa.size() - n0 != 3) begin errs++; $display("FAIL basic_nwrites: got %0d want 3", a_wa.size() - n0); end
    else for (int i = 0; i < 3; i++) begin
      checks++;
      if (a_wa[n0+i] != i || a_wd[n0+i] != int'(w[i])) begin
        errs++; $display("FAIL basic_write%0d: addr=%0d data=%h want %0d %h", i, a_wa[n0+i], a_wd[n0+i], i, w[i]);
      end
    end
    checks++;
    if (a_wc !== 13'd3 || a_cc !== 24'd10 || a_fin !== 1'b1 || a_busy !== 1'b0 || a_to !== 1'b0 || a_ov !== 1'b0) begin
      errs++; $display("FAIL basic_final: wc=%0d cc=%0d fin=%b busy=%b to=%b ov=%b want 3 10 1 0 0 0",
                       a_wc, a_cc, a_fin, a_busy, a_to, a_ov);
    end
  endtask

  task automatic test_valid_gaps();
    int n0;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    n0 = a_wa.size();
    start_load();
    for (int i = 0; i < 4; i++) begin
      in_valid = pat[i]; in_last = (i == 3); in_data = 9'(i + 9'h40);
      checks++;
      if (a_in_ready !== 1'b1) begin errs++; $display("FAIL gaps_ready cycle %0d: got %b want 1", i, a_in_ready); end
      step();
    end
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (a_wa.size() - n0 != 2) begin errs++; $display("FAIL gaps_nwrites: got %0d want 2", a_wa.size() - n0); end
    else begin
      checks++;
      if (a_wa[n0] != 0 || a_wa[n0+1] != 1 || a_wd[n0] != 'h40 || a_wd[n0+1] != 'h43) begin
        errs++; $display("FAIL gaps_writes: %0d:%h %0d:%h want 0:40 1:43", a_wa[n0], a_wd[n0], a_wa[n0+1], a_wd[n0+1]);
      end
    end
  endtask

  task automatic test_overflow();
    int n0;
    do_reset();
    n0 = b_wa.size();
    start_load();
    for (int i = 0; i < 8; i++) send_word(1, 9'(9'h100 + i), 1'b0, 0);
    checks++;
    if (b_ov !== 1'b1 || b_wc !== 4'd8 || b_busy !== 1'b1) begin
      errs++; $display("FAIL ovf_flags: ov=%b wc=%0d busy=%b want 1 8 1", b_ov, b_wc, b_busy);
    end
    in_valid = 1'b1; in_data = 9'h0AA;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (b_in_ready !== 1'b0) begin errs++; $display("FAIL ovf_ninth_ready: got %b want 0", b_in_ready); end
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (b_wa.size() - n0 != 8) begin errs++; $display("FAIL ovf_nwrites: got %0d want 8", b_wa.size() - n0); end
    else for (int i = 0; i < 8; i++) begin
      checks++;
      if (b_wa[n0+i] != i || b_wd[n0+i] != 'h100 + i) begin
        errs++; $display("FAIL ovf_write%0d: addr=%0d data=%h", i, b_wa[n0+i], b_wd[n0+i]);
      end
    end
    checks++;
    if (b_wc !== 4'd8) begin errs++; $display("FAIL ovf_wc_hold: got %0d want 8", b_wc); end
  endtask

  task automatic test_timeout();
    int k;
    do_reset();
    start_load();
    send_word(1, 9'h011, 1'b1, 0);
    wait_run(1);
    k = 0;
    while (!b_fin && k < 30) begin step(); k++; end
    checks++;
    if (b_fin !== 1'b1 || b_to !== 1'b1 || b_cc !== 24'd5) begin
      errs++; $display("FAIL timeout_hit: fin=%b to=%b cc=%0d want 1 1 5", b_fin, b_to, b_cc);
    end
    start_load();
    checks++;
    if (b_to !== 1'b0 || b_cc !== 24'd0 || b_fin !== 1'b0 || b_busy !== 1'b1) begin
      errs++; $display("FAIL rerun_clear: to=%b cc=%0d fin=%b busy=%b want 0 0 0 1", b_to, b_cc, b_fin, b_busy);
    end
    send_word(1, 9'h022, 1'b1, 0);
    wait_run(1);
    run_cycles(5);
    checks++;
    if (b_fin !== 1'b1 || b_to !== 1'b0 || b_cc !== 24'd5) begin
      errs++; $display("FAIL done_at_limit: fin=%b to=%b cc=%0d want 1 0 5", b_fin, b_to, b_cc);
    end
  endtask

  task automatic test_reset_mid_run();
    int n0;
    do_reset();
    start_load();
    send_word(0, 9'h0F0, 1'b0, 0);
    send_word(0, 9'h00F, 1'b1, 0);
    wait_run(0);
    repeat (3) step();
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    checks++;
    if (a_busy !== 1'b1 || a_in_ready !== 1'b0 || a_cc !== 24'd4) begin
      errs++; $display("FAIL run_ignores_load_req: busy=%b rdy=%b cc=%0d want 1 0 4", a_busy, a_in_ready, a_cc);
    end
    repeat (3) step();
    checks++;
    if (a_cc !== 24'd7) begin errs++; $display("FAIL run_cc7: got %0d want 7", a_cc); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_in_ready, a_wr_en, a_start, a_busy, a_fin, a_to, a_ov, a_wr_addr, a_wr_data, a_wc, a_cc} !== '0) begin
      errs++; $display("FAIL reset_mid_run: outputs not all 0 (cc=%0d busy=%b)", a_cc, a_busy);
    end
    repeat (2) step();
    rst_n = 1'b1;
    repeat (5) step();
    checks++;
    if (a_busy !== 1'b0 || a_in_ready !== 1'b0 || a_fin !== 1'b0) begin
      errs++; $display("FAIL post_reset_idle: busy=%b rdy=%b fin=%b want 0 0 0", a_busy, a_in_ready, a_fin);
    end
    // Reset landing on a write strobe must kill it and allow no further strobes.
    start_load();
    n0 = a_wa.size();
    in_valid = 1'b1; in_data = 9'h155;
    step();
    checks++;
    if (a_wr_en !== 1'b1) begin errs++; $display("FAIL inflight_strobe: got %b want 1", a_wr_en); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_wr_en !== 1'b0) begin errs++; $display("FAIL inflight_abandon: got %b want 0", a_wr_en); end
    repeat (3) step();
    rst_n = 1'b1; in_valid = 1'b0;
    repeat (2) step();
    checks++;
    if (a_wa.size() != n0) begin errs++; $display("FAIL inflight_no_write: got %0d writes want 0", a_wa.size() - n0); end
  endtask

  task automatic test_done_early();
    do_reset();
    cpu_done = 1'b1;
    start_load();
    send_word(0, 9'h001, 1'b0, 0);
    send_word(0, 9'h002, 1'b1, 0);
    checks++;
    if (a_busy !== 1'b1 || a_fin !== 1'b0) begin errs++; $display("FAIL done_early_load: busy=%b fin=%b want 1 0", a_busy, a_fin); end
    cpu_done = 1'b1;
    wait_run(0);
    step();
    cpu_done = 1'b0;
    checks++;
    if (a_fin !== 1'b1 || a_cc !== 24'd0 || a_to !== 1'b0 || a_wc !== 13'd2) begin
      errs++; $display("FAIL done_early_run: fin=%b cc=%0d to=%b wc=%0d want 1 0 0 2", a_fin, a_cc, a_to, a_wc);
    end
  endtask

  // Random programs against an arithmetic model of the load/run outcome.
  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int sel, n, nsend, dly, n0, s0, e_cnt, e_cc, gotn;
      bit e_ov, e_to;
      logic [8:0] w[$];
      sel = it % 2;
      n = sel ? $urandom_range(1, 12) : $urandom_range(1, 6);
      dly = sel ? $urandom_range(0, 8) : $urandom_range(0, 20);
      w.delete();
      for (int i = 0; i < n; i++) w.push_back(9'($urandom));
      e_cnt = (sel && n > 8) ? 8 : n;
      e_ov  = sel && n > 8;
      e_to  = sel && dly > 5;
      e_cc  = e_to ? 5 : dly;
      do_reset();
      n0 = sel ? b_wa.size() : a_wa.size();
      s0 = sel ? b_starts : a_starts;
      start_load();
      nsend = e_cnt;
      for (int i = 0; i < nsend; i++) send_word(sel, w[i], i == n - 1, $urandom_range(0, 2));
      wait_run(sel);
      run_cycles(dly);
      gotn = (sel ? b_wa.size() : a_wa.size()) - n0;
      checks++;
      if (gotn != e_cnt) begin errs++; $display("FAIL rnd%0d_nwrites: got %0d want %0d", it, gotn, e_cnt); end
      else for (int i = 0; i < e_cnt; i++) begin
        int ad, da;
        ad = sel ? b_wa[n0+i] : a_wa[n0+i];
        da = sel ? b_wd[n0+i] : a_wd[n0+i];
        checks++;
        if (ad != i || da != int'(w[i])) begin
          errs++; $display("FAIL rnd%0d_write%0d: addr=%0d data=%h want %0d %h", it, i, ad, da, i, w[i]);
        end
      end
      checks++;
      if ((sel ? b_starts : a_starts) - s0 != 2) begin
        errs++; $display("FAIL rnd%0d_start_len: got %0d want 2", it, (sel ? b_starts : a_starts) - s0);
      end
      checks++;
      if ((sel ? int'(b_wc) : int'(a_wc)) != e_cnt || (sel ? b_ov : a_ov) !== e_ov ||
          (sel ? int'(b_cc) : int'(a_cc)) != e_cc || (sel ? b_to : a_to) !== e_to ||
          (sel ? b_fin : a_fin) !== 1'b1) begin
        errs++; $display("FAIL rnd%0d_final: wc=%0d ov=%b cc=%0d to=%b fin=%b want %0d %b %0d %b 1", it,
                         sel ? int'(b_wc) : int'(a_wc), sel ? b_ov : a_ov, sel ? int'(b_cc) : int'(a_cc),
                         sel ? b_to : a_to, sel ? b_fin : a_fin, e_cnt, e_ov, e_cc, e_to);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_valid_gaps();
    test_overflow();
    test_timeout();
    test_reset_mid_run();
    test_done_early();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
